cam_read: RTL and testbench
===========================

CAM_READ -- requirements
Module: cam_read

Interface
REQ-001 The block SHALL have parameter AW, default 15, meaning write address width (log2 of CAM_SCREEN_X*CAM_SCREEN_Y).
REQ-002 The block SHALL have parameter DW, default 8, meaning pixel width (RGB 332).
REQ-003 The block SHALL have parameter CAM_SCREEN_X, default 160, meaning pixels per captured line.
REQ-004 The block SHALL have parameter CAM_SCREEN_Y, default 120, meaning captured lines per frame.
REQ-005 One clock, clk, SHALL be used; reset SHALL be rst, asynchronous and active-low.
REQ-006 clk  input  1  sole clock; driven by camera PCLK; all sampling on rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 init  input  1  capture enable; level-sensitive.
REQ-009 vsync  input  1  camera frame sync, high between frames.
REQ-010 href  input  1  camera line valid, high while pixel bytes are valid.
REQ-011 px_data  input  8  camera byte bus, RGB 565, high byte first.
REQ-012 mem_px_addr  output  AW  buffer_ram_dp write address.
REQ-013 mem_px_data  output  DW  buffer_ram_dp write data, RGB 332.
REQ-014 px_wr  output  1  buffer_ram_dp write strobe, one cycle per pixel.
REQ-015 frame_done  output  1  one-cycle pulse at end of a captured frame.
REQ-016 overflow  output  1  sticky flag; frame delivered more than CAM_SCREEN_X*CAM_SCREEN_Y pixels.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_FRAME and CAPTURE; registered vsync_q SHALL provide edge detection (fall = vsync_q & ~vsync, rise = ~vsync_q & vsync).
REQ-018 IDLE: init=1 -> WAIT_FRAME; otherwise stay; px_wr=0.
REQ-019 WAIT_FRAME: vsync fall -> CAPTURE, mem_px_addr<=0, overflow<=0, byte phase<=0; init=0 -> IDLE.
REQ-020 CAPTURE: vsync rise -> frame_done=1 for exactly one cycle, then WAIT_FRAME if init=1, else IDLE.
REQ-021 In CAPTURE, init dropping SHALL NOT abort the frame; the frame completes and the FSM then goes to IDLE.
REQ-022 In CAPTURE with href=1, phase 0 SHALL latch px_data into the high-byte register and set phase to 1.
REQ-023 In CAPTURE with href=1, phase 1 SHALL set phase to 0 and form the pixel.
REQ-024 Pixel format SHALL be mem_px_data = {hi[7:5], hi[2:0], px_data[4:3]}, i.e. R[4:2], G[5:3], B[4:3].
REQ-025 Latency: px_wr and mem_px_data SHALL be valid in the cycle after the second byte is sampled, with mem_px_addr equal to that pixel's index.
REQ-026 mem_px_addr SHALL increment by 1 in the cycle following each px_wr; the first pixel of a frame SHALL be written at address 0.
REQ-027 href=0 SHALL force phase to 0; a lone high byte at line end SHALL be discarded with no write.
REQ-028 When addr reaches CAM_SCREEN_X*CAM_SCREEN_Y (19200), further pixels SHALL be suppressed (px_wr=0, addr held) and overflow SHALL be set; overflow SHALL clear only on the next frame start or reset.
REQ-029 A vsync rise coincident with a phase-1 byte SHALL prioritise the frame end: no write, frame_done=1.
REQ-030 px_wr SHALL never be high outside CAPTURE.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, phase 0, vsync_q 0, mem_px_addr 0, mem_px_data 0, px_wr 0, frame_done 0 and overflow 0, including mid-frame.
REQ-032 After rst deasserts, capture SHALL start only after a fresh vsync fall; a partial frame in progress SHALL be ignored.

Verification
REQ-033 Bytes 0xF8,0x1F with href=1 after a vsync fall -> px_wr=1 one cycle later, mem_px_data=0xE3, mem_px_addr=0.
REQ-034 Full frame of 120 lines x 320 bytes, then vsync rise -> 19200 px_wr pulses, last addr 19199, one frame_done pulse, overflow=0.
REQ-035 Line of 321 bytes -> 160 writes; odd byte dropped; next line's first pixel formed from its own first two bytes.
REQ-036 Frame of 121 lines -> writes stop at addr 19199, overflow=1 holds into WAIT_FRAME, clears at the next vsync fall.
REQ-037 rst pulsed low mid-line at addr 500 -> all outputs 0 asynchronously; no write until the following vsync fall, then addr restarts at 0.
REQ-038 init=0 during CAPTURE -> current frame completes with frame_done, FSM enters IDLE, and no writes occur on the next frame.

Source files
------------

// File: rtl/cam_read.sv
// Camera capture front end: assembles RGB565 byte pairs from the camera bus
// into RGB332 pixels and streams them into the frame buffer, one write per
// pixel, addressed in raster order from 0 at the start of each frame.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | capture disabled, waiting for init
// WAIT_FRAME | armed, waiting for the vsync falling edge that opens a frame
// CAPTURE    | frame in progress, pairing bytes into pixels until vsync rises
module cam_read #(
  parameter int AW           = 15,
  parameter int DW           = 8,
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          overflow
);

  localparam logic [AW-1:0] FRAME_PX = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            vsync_q;
  logic            phase_q, phase_d;
  // Only the colour bits that survive the 565->332 reduction are kept
  // from the high byte: R[4:2] and G[5:3].
  logic [5:0]      hi_q, hi_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   data_d;
  logic            wr_d;
  logic            done_d;
  logic            ovf_d;
  logic            vs_fall;
  logic            vs_rise;

  assign vs_fall = vsync_q & ~vsync;
  assign vs_rise = ~vsync_q & vsync;

  // Registers for FSM state, byte pairing and all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      mem_px_addr <= '0;
      mem_px_data <= '0;
      px_wr       <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      mem_px_addr <= addr_d;
      mem_px_data <= data_d;
      px_wr       <= wr_d;
      frame_done  <= done_d;
      overflow    <= ovf_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    addr_d  = mem_px_addr;
    data_d  = mem_px_data;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    ovf_d   = overflow;

    // The address trails each write by one cycle so that the write cycle
    // itself presents the pixel's own index.
    if (px_wr) begin
      addr_d = mem_px_addr + AW'(1);
    end

    unique case (state_q)
      IDLE: begin
        phase_d = 1'b0;
        if (init) begin
          state_d = WAIT_FRAME;
        end
      end

      WAIT_FRAME: begin
        phase_d = 1'b0;
        if (vs_fall) begin
          state_d = CAPTURE;
          addr_d  = '0;
          ovf_d   = 1'b0;
        end else if (!init) begin
          state_d = IDLE;
        end
      end

      CAPTURE: begin
        if (vs_rise) begin
          // Frame end wins over a pixel completing in the same cycle.
          done_d  = 1'b1;
          phase_d = 1'b0;
          state_d = init ? WAIT_FRAME : IDLE;
        end else if (href) begin
          if (!phase_q) begin
            hi_d    = {px_data[7:5], px_data[2:0]};
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (mem_px_addr >= FRAME_PX) begin
              ovf_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              data_d = DW'({hi_q, px_data[4:3]});
            end
          end
        end else begin
          // A dangling high byte at end of line is dropped.
          phase_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cam_read.sv
// Directed bench for cam_read: single pixel format, full frame, odd-length
// line, overflow frame, frame-end priority, mid-frame reset and init drop.
module tb_cam_read;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          init;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          frame_done;
  logic          overflow;

  int n_chk  = 0;
  int n_fail = 0;

  int            wr_total   = 0;
  int            done_total = 0;
  int            seq_err    = 0;
  logic [AW-1:0] last_addr  = '0;

  int wr_snap;
  int done_snap;

  cam_read #(
    .AW(AW), .DW(DW), .CAM_SCREEN_X(160), .CAM_SCREEN_Y(120)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/frame monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (px_wr) begin
      if (mem_px_addr != '0 && mem_px_addr != last_addr + AW'(1)) seq_err++;
      last_addr = mem_px_addr;
      wr_total++;
    end
    if (frame_done) done_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    href    = 1'b1;
    px_data = b;
  endtask

  task automatic send_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(8'(i * 37 + 1));
    @(negedge clk);
    href = 1'b0;
  endtask

  // Returns at the negedge that drives vsync low; the next edge sees the fall.
  task automatic start_frame();
    @(negedge clk);
    href  = 1'b0;
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
  endtask

  // Returns at the negedge after the rise was sampled (frame_done visible).
  task automatic end_frame();
    @(negedge clk);
    href  = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; init = 1'b0; vsync = 1'b0; href = 1'b0; px_data = 8'h00;

    // Reset state
    tick(3);
    chk("rst_px_wr", 32'(px_wr), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_addr", 32'(mem_px_addr), 32'd0);
    chk("rst_data", 32'(mem_px_data), 32'd0);
    rst  = 1'b1;
    init = 1'b1;
    tick(2);

    // Single pixel F8,1F -> E3 at address 0, one cycle after the second byte
    start_frame();
    send_byte(8'hF8);
    send_byte(8'h1F);
    @(negedge clk);
    chk("px1_wr", 32'(px_wr), 32'd1);
    chk("px1_data", 32'(mem_px_data), 32'hE3);
    chk("px1_addr", 32'(mem_px_addr), 32'd0);
    href = 1'b0;
    end_frame();
    chk("px1_done", 32'(frame_done), 32'd1);
    tick(1);
    chk("px1_done_pulse", 32'(frame_done), 32'd0);

    // vsync rise together with a second byte: frame end wins, no write
    start_frame();
    send_byte(8'hF8);
    @(negedge clk);
    px_data = 8'h1F;
    vsync   = 1'b1;
    @(negedge clk);
    href = 1'b0;
    chk("prio_wr", 32'(px_wr), 32'd0);
    chk("prio_done", 32'(frame_done), 32'd1);
    tick(2);

    // Full 120 x 320-byte frame
    start_frame();
    wr_snap = wr_total; done_snap = done_total;
    for (int l = 0; l < 120; l++) send_line(320);
    end_frame();
    chk("full_done", 32'(frame_done), 32'd1);
    tick(1);
    chk("full_writes", 32'(wr_total - wr_snap), 32'd19200);
    chk("full_last_addr", 32'(last_addr), 32'd19199);
    chk("full_done_cnt", 32'(done_total - done_snap), 32'd1);
    chk("full_ovf", 32'(overflow), 32'd0);
    chk("full_seq", 32'(seq_err), 32'd0);

    // 321-byte line: odd byte dropped, next line pairs from its own bytes
    start_frame();
    wr_snap = wr_total;
    send_line(321);
    chk("odd_writes", 32'(wr_total - wr_snap), 32'd160);
    send_byte(8'hF8);
    send_byte(8'h1F);
    @(negedge clk);
    href = 1'b0;
    chk("odd_next_wr", 32'(px_wr), 32'd1);
    chk("odd_next_data", 32'(mem_px_data), 32'hE3);
    chk("odd_next_addr", 32'(mem_px_addr), 32'd160);
    end_frame();
    tick(2);

    // 121-line frame: writes stop at 19199, overflow sticks until next fall
    start_frame();
    wr_snap = wr_total; done_snap = done_total;
    for (int l = 0; l < 121; l++) send_line(320);
    end_frame();
    tick(1);
    chk("ovf_writes", 32'(wr_total - wr_snap), 32'd19200);
    chk("ovf_last_addr", 32'(last_addr), 32'd19199);
    chk("ovf_set", 32'(overflow), 32'd1);
    tick(3);
    chk("ovf_hold_wait", 32'(overflow), 32'd1);
    start_frame();
    chk("ovf_before_fall", 32'(overflow), 32'd1);
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Mid-line reset at address 500
    send_line(320);
    send_line(320);
    for (int i = 0; i < 360; i++) send_byte(8'(i + 3));
    send_byte(8'h12);
    @(negedge clk);
    chk("mid_addr500", 32'(mem_px_addr), 32'd500);
    px_data = 8'h34;
    #2 rst = 1'b0;
    #1;
    chk("arst_addr", 32'(mem_px_addr), 32'd0);
    chk("arst_data", 32'(mem_px_data), 32'd0);
    chk("arst_wr", 32'(px_wr), 32'd0);
    chk("arst_done", 32'(frame_done), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wr_snap = wr_total; done_snap = done_total;
    send_line(40);
    chk("arst_partial_writes", 32'(wr_total - wr_snap), 32'd0);
    end_frame();
    tick(1);
    chk("arst_partial_done", 32'(done_total - done_snap), 32'd0);
    start_frame();
    send_byte(8'hF8);
    send_byte(8'h1F);
    @(negedge clk);
    href = 1'b0;
    chk("arst_restart_wr", 32'(px_wr), 32'd1);
    chk("arst_restart_addr", 32'(mem_px_addr), 32'd0);
    chk("arst_restart_data", 32'(mem_px_data), 32'hE3);

    // init dropped mid-frame: frame completes, then capture stops
    tick(1);
    init = 1'b0;
    wr_snap = wr_total;
    send_line(20);
    end_frame();
    chk("init_drop_done", 32'(frame_done), 32'd1);
    tick(1);
    chk("init_drop_writes", 32'(wr_total - wr_snap), 32'd10);
    wr_snap = wr_total; done_snap = done_total;
    start_frame();
    send_line(20);
    end_frame();
    tick(1);
    chk("idle_writes", 32'(wr_total - wr_snap), 32'd0);
    chk("idle_done", 32'(done_total - done_snap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
